ob_cmd_arb: RTL and testbench
=============================

# ob_cmd_arb

Round-robin command arbiter in front of the order-book ingress interface. Multiple requesters (market-data gateways, risk engine, admin port) each present one `ob_pkg::cmd_t` at a time, and the arbiter selects one per cycle. It drives the registered `cmd_vld_r`/`cmd_r` pair into `ob`, honouring `cmd_full_r`. A burst limit lets a granted port hold the book for a bounded number of consecutive commands before the grant rotates.

## Interface

Parameters:
- `N_PORTS`, default 4: number of requester ports, 2..8.
- `BURST_N`, default 4: maximum consecutive commands per grant, 1..15.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: one clock, reset synchronous and active-high.
- `req_vld`  in  N_PORTS: per-port command valid.
- `req_cmd`  in  N_PORTS x $bits(ob_pkg::cmd_t): per-port command.
- `req_accept`  out  N_PORTS: one-hot or zero. Combinational. The port's command is consumed this cycle.
- `cmd_vld_r`  out  1: registered command valid to `ob`.
- `cmd_r`  out  ob_pkg::cmd_t: registered command to `ob`.
- `cmd_full_r`  in  1: `ob` ingress full, registered by `ob`.
- `grant_port_r`  out  $clog2(N_PORTS): port currently holding the grant. Valid when `grant_vld_r`.
- `grant_vld_r`  out  1: a port holds the grant (state LOCK).

## Operation

- The state machine has two states, IDLE and LOCK, plus `burst_cnt_r` (4 bits) and `rr_ptr_r` (last-served port).
- Issue condition in cycle t: `issue = ~cmd_full_r & (selected port's req_vld)`.
  - On issue, `req_accept[sel]=1`.
  - `cmd_r <= req_cmd[sel]` and `cmd_vld_r <= 1` at t+1.
  - Otherwise `cmd_vld_r <= 0`. `cmd_r` holds its value.
- IDLE:
  - `sel` = first port with `req_vld` searching from `rr_ptr_r+1` modulo N_PORTS.
  - On issue: go to LOCK, `grant_port_r<=sel`, `burst_cnt_r<=1`, `rr_ptr_r<=sel`.
  - If `BURST_N==1`, stay IDLE instead. `rr_ptr_r` still updates.
  - With no requests, or `cmd_full_r=1`, stay IDLE; the pointer does not move.
- LOCK:
  - `sel = grant_port_r`. On issue, `burst_cnt_r++`.
  - Return to IDLE when any of the following holds:
    - `burst_cnt_r` reaches `BURST_N` on this issue;
    - the granted port drops `req_vld` in a cycle with `cmd_full_r=0` (yield);
    - the granted port's `req_vld=1` but `cmd_full_r=1` while another port is requesting (yield on stall).
  - Returning to IDLE takes effect in the same cycle as the triggering issue. The next cycle selects a fresh port with no bubble beyond the state update.
- Backpressure: no command is accepted while `cmd_full_r=1`. A command, once accepted, is never dropped or duplicated.
- Requester rule:
  - `req_cmd` must be stable while `req_vld=1` and `req_accept=0`.
  - `req_vld` may deassert without acceptance. The arbiter tolerates this; it is not an error.
- Cancels are treated identically to other commands. No reordering occurs within a port.
- `rr_ptr_r` wraps from N_PORTS-1 to 0.

## Timing

- Reset values:
  - `cmd_vld_r=0`, `cmd_r='0`, `req_accept=0`.
  - `grant_vld_r=0`, `grant_port_r=0`.
  - `rr_ptr_r=N_PORTS-1`, so port 0 has first priority.
  - `burst_cnt_r=0`, state IDLE.
- Latency: `req_accept` to `cmd_vld_r` is 1 cycle. Throughput is 1 command/cycle while `cmd_full_r=0`.
- `req_accept` depends combinationally on `req_vld`, `cmd_full_r` and state.
- Reset asserted mid-burst:
  - aborts the grant;
  - a command registered in `cmd_r` but not yet presented (`cmd_vld_r` pending) is discarded;
  - no `req_accept` is asserted during reset.

## Configuration

- `OB_CMD_ARB_STARVE_CNT_EN` defined:
  - adds output `starve_max_r`, N_PORTS x 8 bits;
  - per port, this is the longest run of consecutive cycles with `req_vld=1` and `req_accept=0` since reset, saturating at 255;
  - the current-run counter clears on accept or on `req_vld=0`;
  - both counters reset to 0.
- Undefined: the port and counters are absent. Arbitration is unchanged.

## Structure

- Add to `ob_pkg`:
  - `localparam OB_ARB_PORT_MAX_N = 8`;
  - `typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t`.
- Sub-module `ob_rr_pick`: combinational rotating priority picker (request vector, pointer in, one-hot + index out). Used only in IDLE.
- Everything else lives in `ob_cmd_arb` itself.

## Test plan

- Single port: port 2 drives 3 commands back-to-back with `cmd_full_r=0`.
  - `req_accept[2]` for 3 cycles;
  - `cmd_vld_r` cycles 1-3 later with matching `cmd_r`;
  - state then returns to IDLE.
- Burst limit: `BURST_N=4`, ports 0 and 1 both request continuously.
  - Accept sequence 0,0,0,0,1,1,1,1,0 and so on;
  - `grant_port_r` tracks the sequence.
- Backpressure: `cmd_full_r=1` for 5 cycles with port 3 requesting.
  - No `req_accept`, `cmd_vld_r=0`;
  - on release, the first accept occurs the same cycle and the command appears exactly once.
- Yield: port 1 locked, drops `req_vld` after 2 commands while port 2 requests.
  - Next accept is port 2 within 1 cycle;
  - `burst_cnt` restarts at 1.
- Reset mid-burst: port 0 locked with `burst_cnt=2`, `rst` pulsed 1 cycle.
  - All outputs take their reset values;
  - the next accept is port 0 (pointer reset), with `burst_cnt=1`.
- With `OB_CMD_ARB_STARVE_CNT_EN`: port 3 held off 7 cycles by bursts on ports 0 and 1.
  - `starve_max_r[3]=7`; it stays 7 after a subsequent shorter wait.

Source files
------------

// File: rtl/ob_pkg.sv
// Shared order-book types: the ingress command word and the ingress arbiter state.
// No logic here; imported by the arbiter and its picker.
package ob_pkg;

    localparam int OB_ARB_PORT_MAX_N = 8;

    typedef enum logic [1:0] {
        OB_OP_NEW    = 2'd0,
        OB_OP_CANCEL = 2'd1,
        OB_OP_MODIFY = 2'd2,
        OB_OP_CLEAR  = 2'd3
    } ob_op_t;

    typedef struct packed {
        ob_op_t      op;
        logic        side;
        logic [11:0] oid;
        logic [15:0] price;
        logic [15:0] qty;
    } cmd_t;

    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

endpackage

// File: rtl/ob_rr_pick.sv
// Rotating-priority picker: first requester strictly after i_ptr, wrapping modulo N.
// Purely combinational, no backpressure of its own.
module ob_rr_pick
    import ob_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
)(
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx,
    output logic         o_vld
);

    always_comb begin
        int p;
        p     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        // Walk from the farthest candidate inward so the nearest request wins.
        for (int k = N; k >= 1; k--) begin
            p = (int'(i_ptr) + k) % N;
            if (i_req[p]) begin
                o_gnt    = '0;
                o_gnt[p] = 1'b1;
                o_idx    = W'(p);
                o_vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ob_cmd_arb.sv
// Round-robin burst-limited arbiter feeding order-book ingress; OB_CMD_ARB_STARVE_CNT_EN adds starve_max_r.
// Latency: req_accept (combinational) to cmd_vld_r/cmd_r is one cycle, one command per cycle.
// Backpressure: nothing is accepted while cmd_full_r is high; a stalled lock yields if others wait.
module ob_cmd_arb
    import ob_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int BURST_N = 4
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS-1:0]            req_vld,
    input  cmd_t [N_PORTS-1:0]            req_cmd,
    output logic [N_PORTS-1:0]            req_accept,
    output logic                          cmd_vld_r,
    output cmd_t                          cmd_r,
    input  logic                          cmd_full_r,
    output logic [$clog2(N_PORTS)-1:0]    grant_port_r,
    output logic                          grant_vld_r
`ifdef OB_CMD_ARB_STARVE_CNT_EN
    ,
    output logic [N_PORTS-1:0][7:0]       starve_max_r
`endif
);

    localparam int         PW        = $clog2(N_PORTS);
    localparam logic [3:0] BURST_LIM = 4'(BURST_N);

    arb_state_t         r_state;
    logic [3:0]         r_burst_cnt;
    logic [PW-1:0]      r_rr_ptr;

    logic [N_PORTS-1:0] w_pick_gnt;
    logic [PW-1:0]      w_pick_idx;
    logic               w_pick_vld;
    logic [N_PORTS-1:0] w_sel_oh;
    logic [PW-1:0]      w_sel;
    logic               w_sel_vld;
    logic               w_issue;
    logic               w_others;
    logic [3:0]         w_cnt_inc;

    ob_rr_pick #(.N(N_PORTS)) u_pick (
        .i_req (req_vld),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_vld (w_pick_vld)
    );

    always_comb begin
        w_sel_oh = '0;
        if (r_state == ARB_LOCK) begin
            w_sel                  = grant_port_r;
            w_sel_vld              = req_vld[grant_port_r];
            w_sel_oh[grant_port_r] = 1'b1;
        end else begin
            w_sel     = w_pick_idx;
            w_sel_vld = w_pick_vld;
            w_sel_oh  = w_pick_gnt;
        end
        w_issue    = ~rst & ~cmd_full_r & w_sel_vld;
        req_accept = w_issue ? w_sel_oh : '0;
        w_others   = |(req_vld & ~w_sel_oh);
        w_cnt_inc  = r_burst_cnt + 4'd1;
    end

    assign grant_vld_r = (r_state == ARB_LOCK);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_burst_cnt  <= '0;
            r_rr_ptr     <= PW'(N_PORTS - 1);
            grant_port_r <= '0;
            cmd_vld_r    <= 1'b0;
            cmd_r        <= '0;
        end else begin
            cmd_vld_r <= w_issue;
            if (w_issue) begin
                cmd_r <= req_cmd[w_sel];
            end
            if (r_state == ARB_IDLE) begin
                if (w_issue) begin
                    grant_port_r <= w_sel;
                    r_rr_ptr     <= w_sel;
                    r_burst_cnt  <= 4'd1;
                    if (BURST_N > 1) begin
                        r_state <= ARB_LOCK;
                    end
                end
            end else if (w_issue) begin
                r_burst_cnt <= w_cnt_inc;
                if (w_cnt_inc == BURST_LIM) begin
                    r_state <= ARB_IDLE;
                end
            end else if (~cmd_full_r || (w_sel_vld && w_others)) begin
                // Holder went quiet, or is stalled while someone else could use the slot.
                r_state <= ARB_IDLE;
            end
        end
    end

`ifdef OB_CMD_ARB_STARVE_CNT_EN
    logic [N_PORTS-1:0][7:0] r_starve_cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cur <= '0;
            starve_max_r <= '0;
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (req_vld[p] && !req_accept[p]) begin
                    if (r_starve_cur[p] != 8'hFF) begin
                        r_starve_cur[p] <= r_starve_cur[p] + 8'd1;
                        if ((r_starve_cur[p] + 8'd1) > starve_max_r[p]) begin
                            starve_max_r[p] <= r_starve_cur[p] + 8'd1;
                        end
                    end
                end else begin
                    r_starve_cur[p] <= '0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ob_cmd_arb.sv
// Bench for ob_cmd_arb: directed scenarios plus randomized traffic against a behavioural model.
module tb_ob_cmd_arb;
    import ob_pkg::*;

    localparam int N  = 4;
    localparam int BN = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_vld;
    cmd_t [N-1:0]         req_cmd;
    logic [N-1:0]         req_accept;
    logic                 cmd_vld_r;
    cmd_t                 cmd_r;
    logic                 cmd_full_r;
    logic [$clog2(N)-1:0] grant_port_r;
    logic                 grant_vld_r;
`ifdef OB_CMD_ARB_STARVE_CNT_EN
    logic [N-1:0][7:0]    starve_max_r;
`endif

    ob_cmd_arb #(.N_PORTS(N), .BURST_N(BN)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_vld      (req_vld),
        .req_cmd      (req_cmd),
        .req_accept   (req_accept),
        .cmd_vld_r    (cmd_vld_r),
        .cmd_r        (cmd_r),
        .cmd_full_r   (cmd_full_r),
        .grant_port_r (grant_port_r),
        .grant_vld_r  (grant_vld_r)
`ifdef OB_CMD_ARB_STARVE_CNT_EN
        ,
        .starve_max_r (starve_max_r)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: "locked to a port" flag, last-served pointer, commands in the current burst.
    bit   m_lock;
    int   m_gport;
    int   m_ptr;
    int   m_cnt;
    bit   m_cmd_vld;
    cmd_t m_cmd;
    int   m_cur [N];
    int   m_max [N];

    logic [N-1:0] want;
    logic [N-1:0] dut_acc;
    int           seq [N];
    int           acc_log [$];
    int           exp_q [$];
    int           vld_cnt;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int model_sel();
        if (rst || cmd_full_r) return -1;
        if (!m_lock) begin
            for (int k = 1; k <= N; k++) begin
                if (req_vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
            end
            return -1;
        end
        return req_vld[m_gport] ? m_gport : -1;
    endfunction

    task automatic model_reset();
        m_lock = 0; m_gport = 0; m_ptr = N - 1; m_cnt = 0;
        m_cmd_vld = 0; m_cmd = '0;
        for (int p = 0; p < N; p++) begin
            m_cur[p] = 0;
            m_max[p] = 0;
        end
    endtask

    task automatic model_update();
        int s;
        int others;
        if (rst) begin
            model_reset();
            return;
        end
        s = model_sel();
        for (int p = 0; p < N; p++) begin
            if (req_vld[p] && s != p) begin
                m_cur[p] = (m_cur[p] < 255) ? m_cur[p] + 1 : 255;
                if (m_cur[p] > m_max[p]) m_max[p] = m_cur[p];
            end else begin
                m_cur[p] = 0;
            end
        end
        m_cmd_vld = (s >= 0);
        if (s >= 0) m_cmd = req_cmd[s];
        others = 0;
        for (int p = 0; p < N; p++) if (req_vld[p] && p != m_gport) others = 1;
        if (!m_lock) begin
            if (s >= 0) begin
                m_ptr = s; m_gport = s; m_cnt = 1; m_lock = (BN > 1);
            end
        end else if (s >= 0) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == BN) m_lock = 0;
        end else if (!cmd_full_r) begin
            m_lock = 0;
        end else if (req_vld[m_gport] && others != 0) begin
            m_lock = 0;
        end
    endtask

    task automatic check();
        int s;
        int a;
        logic [N-1:0] exp_acc;
        s = model_sel();
        exp_acc = '0;
        if (s >= 0) exp_acc[s] = 1'b1;
        dut_acc = req_accept;
        chk("req_accept", 64'(req_accept), 64'(exp_acc));
        chk("cmd_vld_r", 64'(cmd_vld_r), 64'(m_cmd_vld));
        chk("cmd_r", 64'(cmd_r), 64'(m_cmd));
        chk("grant_vld_r", 64'(grant_vld_r), 64'(m_lock));
        if (m_lock) chk("grant_port_r", 64'(grant_port_r), 64'(m_gport));
`ifdef OB_CMD_ARB_STARVE_CNT_EN
        for (int p = 0; p < N; p++) chk("starve_max_r", 64'(starve_max_r[p]), 64'(m_max[p]));
`endif
        a = -1;
        for (int p = 0; p < N; p++) if (req_accept[p]) a = p;
        acc_log.push_back(a);
        if (cmd_vld_r) vld_cnt++;
    endtask

    function automatic cmd_t mk_cmd(input int p);
        cmd_t c;
        c.op    = ob_op_t'($urandom_range(0, 3));
        c.side  = 1'($urandom_range(0, 1));
        c.oid   = {2'(p), 10'(seq[p])};
        c.price = 16'($urandom);
        c.qty   = 16'($urandom);
        return c;
    endfunction

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            if (want[p]) begin
                if (!req_vld[p] || dut_acc[p]) begin
                    req_cmd[p] = mk_cmd(p);
                    seq[p]++;
                end
                req_vld[p] = 1'b1;
            end else begin
                req_vld[p] = 1'b0;
            end
        end
    endtask

    task automatic set_want(input logic [N-1:0] w);
        want = w;
        drive();
    endtask

    task automatic tick();
        @(negedge clk);
        check();
        @(posedge clk);
        model_update();
        #1;
        drive();
    endtask

    task automatic clear_log();
        acc_log.delete();
        vld_cnt = 0;
    endtask

    task automatic chk_seq(input string nm);
        chk({nm, "_len"}, 64'(acc_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++) begin
            chk(nm, 64'(acc_log[i]), 64'(exp_q[i]));
        end
    endtask

    initial begin
        rst = 1'b1; cmd_full_r = 1'b0; req_vld = '0; req_cmd = '0;
        want = '0; dut_acc = '0; vld_cnt = 0;
        for (int p = 0; p < N; p++) seq[p] = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        tick();
        chk("rst_cmd_vld", 64'(cmd_vld_r), 64'd0);
        chk("rst_cmd_r", 64'(cmd_r), 64'd0);
        chk("rst_grant_vld", 64'(grant_vld_r), 64'd0);
        chk("rst_grant_port", 64'(grant_port_r), 64'd0);
        chk("rst_accept", 64'(req_accept), 64'd0);
        rst = 1'b0;

        // Single port, three back-to-back commands.
        clear_log();
        set_want(4'b0100);
        repeat (3) tick();
        set_want(4'b0000);
        repeat (3) tick();
        exp_q = '{2, 2, 2, -1, -1, -1};
        chk_seq("single_seq");
        chk("single_vld_cnt", 64'(vld_cnt), 64'd3);
        chk("single_idle", 64'(grant_vld_r), 64'd0);

        // Burst limit with two continuous requesters.
        clear_log();
        set_want(4'b0011);
        repeat (9) tick();
        exp_q = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        chk_seq("burst_seq");
        set_want(4'b0000);
        repeat (2) tick();

        // Backpressure for five cycles, then release.
        clear_log();
        cmd_full_r = 1'b1;
        set_want(4'b1000);
        repeat (5) tick();
        cmd_full_r = 1'b0;
        tick();
        set_want(4'b0000);
        repeat (3) tick();
        exp_q = '{-1, -1, -1, -1, -1, 3, -1, -1, -1};
        chk_seq("bp_seq");
        chk("bp_vld_cnt", 64'(vld_cnt), 64'd1);

        // Yield: port 1 drops after two commands, port 2 takes over with a fresh burst.
        clear_log();
        set_want(4'b0010);
        repeat (2) tick();
        set_want(4'b0100);
        tick();
        set_want(4'b0101);
        repeat (5) tick();
        exp_q = '{1, 1, -1, 2, 2, 2, 2, 0};
        chk_seq("yield_seq");
        set_want(4'b0000);
        repeat (2) tick();

        // Reset in the middle of a burst on port 0.
        clear_log();
        set_want(4'b0001);
        repeat (2) tick();
        rst = 1'b1;
        set_want(4'b0011);
        tick();
        rst = 1'b0;
        chk("mid_rst_cmd_vld", 64'(cmd_vld_r), 64'd0);
        chk("mid_rst_cmd_r", 64'(cmd_r), 64'd0);
        chk("mid_rst_grant_vld", 64'(grant_vld_r), 64'd0);
        chk("mid_rst_grant_port", 64'(grant_port_r), 64'd0);
        clear_log();
        repeat (5) tick();
        exp_q = '{0, 0, 0, 0, 1};
        chk_seq("post_rst_seq");

        // Port 3 held off by bursts on ports 0 and 1.
        set_want(4'b0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_log();
        set_want(4'b0011);
        tick();
        set_want(4'b1011);
        repeat (11) tick();
        exp_q = '{0, 0, 0, 0, 1, 1, 1, 1, 3, 3, 3, 3};
        chk_seq("starve_seq");
        set_want(4'b0000);
        repeat (2) tick();
`ifdef OB_CMD_ARB_STARVE_CNT_EN
        chk("starve_max3", 64'(starve_max_r[3]), 64'd7);
`endif
        set_want(4'b1001);
        repeat (6) tick();
`ifdef OB_CMD_ARB_STARVE_CNT_EN
        chk("starve_max3_hold", 64'(starve_max_r[3]), 64'd7);
`endif
        set_want(4'b0000);
        repeat (2) tick();

        // Randomized traffic with backpressure, drops without accept and rare resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) want = 4'($urandom_range(0, 15));
            cmd_full_r = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) == 0);
            drive();
            tick();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
